// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  cache_pkg
//  Shared types, default widths and address helper for the cache fetch path.
//  Revision: 1.0
// ============================================================================
package cache_pkg;

    localparam int C_SIZE_BLOCK = 32;
    localparam int C_BIT_TOTAL  = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_FILL     = 3'd5,
        ST_RESP     = 3'd6
    } fetch_state_t;

    // Full-width byte address; callers truncate to their memory address width.
    function automatic logic [63:0] block_to_byte_addr(input logic [63:0] base,
                                                       input logic [63:0] idx,
                                                       input int unsigned block_bits);
        return base + idx * 64'(block_bits / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_fetch_sat_counter.sv
`default_nettype none
// ============================================================================
//  sat_counter
//  Event counter that sticks at all-ones instead of wrapping.
//  Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_fetch.sv
`default_nettype none
// ============================================================================
//  cache_fetch
//  Read-miss controller: probes the cache, fetches misses over Avalon-MM,
//  fills the cache and returns the block; one request in flight.
//  Revision: 1.0
// ============================================================================
module cache_fetch
    import cache_pkg::*;
#(
    parameter int          SIZE_BLOCK   = C_SIZE_BLOCK,
    parameter int          BIT_TOTAL    = C_BIT_TOTAL,
    parameter logic [63:0] BASE_ADDR    = 64'h0,
    parameter int          BIT_MEM_ADDR = 32,
    parameter int          BIT_CNT      = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [BIT_TOTAL-1:0]    i_req_addr,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [SIZE_BLOCK-1:0]   o_rsp_data,
    output logic                    o_cache_en,
    output logic                    o_cache_wrt,
    output logic [BIT_TOTAL-1:0]    o_cache_addr,
    output logic [SIZE_BLOCK-1:0]   o_cache_data,
    input  logic [SIZE_BLOCK-1:0]   i_cache_data,
    input  logic                    i_cache_success,
    output logic                    o_mem_read,
    output logic [BIT_MEM_ADDR-1:0] o_mem_addr,
    input  logic                    i_mem_waitrequest,
    input  logic [SIZE_BLOCK-1:0]   i_mem_readdata,
    input  logic                    i_mem_readdatavalid,
    output logic [BIT_CNT-1:0]      o_hit_cnt,
    output logic [BIT_CNT-1:0]      o_miss_cnt
);

    fetch_state_t            r_state;
    logic [BIT_TOTAL-1:0]    r_addr;
    logic [SIZE_BLOCK-1:0]   r_data;
    logic                    r_cache_en;
    logic                    r_cache_wrt;
    logic                    r_mem_read;
    logic [BIT_MEM_ADDR-1:0] r_mem_addr;
    logic                    r_rsp_valid;
    logic                    w_hit_inc;
    logic                    w_miss_inc;

    assign w_hit_inc  = (r_state == ST_CHECK) &&  i_cache_success;
    assign w_miss_inc = (r_state == ST_CHECK) && !i_cache_success;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_data      <= '0;
            r_cache_en  <= 1'b0;
            r_cache_wrt <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_addr      <= i_req_addr;
                        r_mem_addr  <= BIT_MEM_ADDR'(block_to_byte_addr(
                                           BASE_ADDR, 64'(i_req_addr), SIZE_BLOCK));
                        r_cache_en  <= 1'b1;
                        r_cache_wrt <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_cache_en <= 1'b0;
                    r_state    <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (i_cache_success) begin
                        r_data      <= i_cache_data;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_mem_read <= 1'b1;
                        r_state    <= ST_MEM_REQ;
                    end
                end
                ST_MEM_REQ: begin
                    if (!i_mem_waitrequest) begin
                        r_mem_read <= 1'b0;
                        // Zero-latency memories may return data on the accept cycle.
                        if (i_mem_readdatavalid) begin
                            r_data      <= i_mem_readdata;
                            r_cache_en  <= 1'b1;
                            r_cache_wrt <= 1'b1;
                            r_state     <= ST_FILL;
                        end else begin
                            r_state <= ST_MEM_WAIT;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_mem_readdatavalid) begin
                        r_data      <= i_mem_readdata;
                        r_cache_en  <= 1'b1;
                        r_cache_wrt <= 1'b1;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    r_cache_en  <= 1'b0;
                    r_cache_wrt <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_cache_en  <= 1'b0;
                    r_cache_wrt <= 1'b0;
                    r_mem_read  <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_data;
    assign o_cache_en   = r_cache_en;
    assign o_cache_wrt  = r_cache_wrt;
    assign o_cache_addr = r_addr;
    assign o_cache_data = r_data;
    assign o_mem_read   = r_mem_read;
    assign o_mem_addr   = r_mem_addr;

    sat_counter #(.WIDTH(BIT_CNT)) u_hit_cnt (
        .clk   (i_clk),
        .rst_n (i_rst),
        .inc   (w_hit_inc),
        .count (o_hit_cnt)
    );

    sat_counter #(.WIDTH(BIT_CNT)) u_miss_cnt (
        .clk   (i_clk),
        .rst_n (i_rst),
        .inc   (w_miss_inc),
        .count (o_miss_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_fetch.sv
`default_nettype none
// ============================================================================
//  tb_cache_fetch
//  Randomized scoreboard bench for cache_fetch with cache and memory models.
//  Revision: 1.0
// ============================================================================
module tb_cache_fetch;

    localparam int          SB      = 32;
    localparam int          BT      = 24;
    localparam int          BMA     = 32;
    localparam int          BC      = 2;
    localparam logic [63:0] BASE    = 64'h1000;
    localparam int          CNT_MAX = (1 << BC) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [BT-1:0]  req_addr = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [SB-1:0]  rsp_data;
    logic           cache_en, cache_wrt;
    logic [BT-1:0]  cache_addr;
    logic [SB-1:0]  cache_wdata;
    logic [SB-1:0]  cache_rdata = '0;
    logic           cache_success = 1'b0;
    logic           mem_read;
    logic [BMA-1:0] mem_addr;
    logic           mem_wait = 1'b0;
    logic [SB-1:0]  mem_rdata = '0;
    logic           mem_rdv = 1'b0;
    logic [BC-1:0]  hit_cnt, miss_cnt;

    cache_fetch #(
        .SIZE_BLOCK(SB), .BIT_TOTAL(BT), .BASE_ADDR(BASE),
        .BIT_MEM_ADDR(BMA), .BIT_CNT(BC)
    ) dut (
        .i_clk(clk), .i_rst(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_cache_en(cache_en), .o_cache_wrt(cache_wrt), .o_cache_addr(cache_addr),
        .o_cache_data(cache_wdata), .i_cache_data(cache_rdata),
        .i_cache_success(cache_success),
        .o_mem_read(mem_read), .o_mem_addr(mem_addr), .i_mem_waitrequest(mem_wait),
        .i_mem_readdata(mem_rdata), .i_mem_readdatavalid(mem_rdv),
        .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            addr;
        logic [SB-1:0] data;
        bit            hit;
        int            hcnt;
        int            mcnt;
        int            t_acc;
        int            wr;
        int            lat;
    } exp_t;

    exp_t          q[$];
    bit            present[int];
    logic [SB-1:0] mem[int];
    logic [SB-1:0] cmem[int];
    int m_hit = 0, m_miss = 0;
    int k_lat = 1, wait_left = 0, stall_left = 0;
    int n_read_acc = 0, n_read_cyc = 0, n_fill = 0;
    bit seen_valid = 0, expect_idle = 0;
    int n_checks = 0, n_fail = 0;

    function automatic logic [SB-1:0] mem_val(input int a);
        if (mem.exists(a)) return mem[a];
        return (SB'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: waitrequest stalls, then data after k_lat cycles (0 = on accept).
    initial begin
        int cd;
        logic [SB-1:0] pend;
        cd = 0;
        pend = '0;
        forever begin
            @(negedge clk);
            mem_rdv   = 1'b0;
            mem_rdata = $urandom;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_rdv   = 1'b1;
                    mem_rdata = pend;
                end
            end
            if (mem_read && rst_n) begin
                if (wait_left > 0) begin
                    mem_wait = 1'b1;
                    wait_left--;
                end else begin
                    mem_wait = 1'b0;
                    n_read_acc++;
                    pend = mem_val(int'((64'(mem_addr) - BASE) >> 2));
                    if (k_lat == 0) begin
                        mem_rdv   = 1'b1;
                        mem_rdata = pend;
                    end else begin
                        cd = k_lat;
                    end
                end
            end else begin
                mem_wait = 1'($urandom_range(0, 1));
            end
        end
    end

    // Cache: registered response one cycle after the enable cycle.
    initial begin
        bit pend_rd, pend_wr;
        int pa;
        pend_rd = 0;
        pend_wr = 0;
        pa = 0;
        forever begin
            @(negedge clk);
            cache_success = 1'b0;
            cache_rdata   = $urandom;
            if (pend_rd && cmem.exists(pa)) begin
                cache_success = 1'b1;
                cache_rdata   = cmem[pa];
            end else if (pend_wr) begin
                cache_success = 1'b1;
            end
            pend_rd = rst_n && cache_en && !cache_wrt;
            pend_wr = rst_n && cache_en && cache_wrt;
            pa = int'(cache_addr);
            if (pend_wr) cmem[pa] = cache_wdata;
        end
    end

    // Client response side: stall for stall_left cycles, then accept.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid && rst_n) begin
                if (stall_left > 0) begin
                    rsp_ready = 1'b0;
                    stall_left--;
                end else begin
                    rsp_ready = 1'b1;
                end
            end else begin
                rsp_ready = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) continue;
            if (cache_en && cache_wrt) begin
                n_fill++;
                if (q.size() == 0) check("spurious_fill", 1, 0);
                else begin
                    check("fill_addr", 64'(cache_addr), 64'(q[0].addr));
                    check("fill_data", 64'(cache_wdata), 64'(q[0].data));
                end
            end
            if (mem_read) begin
                n_read_cyc++;
                if (q.size() == 0) check("spurious_mem_read", 1, 0);
                else check("mem_addr", 64'(mem_addr), BASE + 64'(q[0].addr) * 4);
            end
            if (rsp_valid) begin
                if (q.size() == 0) check("spurious_rsp", 1, 0);
                else begin
                    if (!seen_valid) begin
                        seen_valid = 1;
                        check("rsp_latency", 64'(cyc - q[0].t_acc),
                              64'(q[0].hit ? 3 : 5 + q[0].wr + q[0].lat));
                    end
                    check("rsp_data", 64'(rsp_data), 64'(q[0].data));
                    check("req_ready_in_resp", 64'(req_ready), 0);
                    check("bus_idle_in_resp", {62'd0, cache_en, mem_read}, 0);
                    if (rsp_ready) begin
                        check("hit_cnt", 64'(hit_cnt), 64'(q[0].hcnt));
                        check("miss_cnt", 64'(miss_cnt), 64'(q[0].mcnt));
                        check("mem_accepts", 64'(n_read_acc), q[0].hit ? 0 : 1);
                        check("fills", 64'(n_fill), q[0].hit ? 0 : 1);
                        check("mem_read_cycles", 64'(n_read_cyc), 64'(q[0].hit ? 0 : q[0].wr + 1));
                        void'(q.pop_front());
                        n_read_acc = 0;
                        n_read_cyc = 0;
                        n_fill = 0;
                        seen_valid = 0;
                        expect_idle = 1;
                        continue;
                    end
                end
            end
            if (expect_idle) begin
                check("idle_after_handshake", 64'(req_ready), 1);
                expect_idle = 0;
            end
        end
    end

    function automatic exp_t make_exp(input int a, input int w, input int l);
        exp_t e;
        e.addr = a;
        e.hit  = present.exists(a);
        e.data = mem_val(a);
        if (e.hit) m_hit  = (m_hit  < CNT_MAX) ? m_hit  + 1 : m_hit;
        else       m_miss = (m_miss < CNT_MAX) ? m_miss + 1 : m_miss;
        present[a] = 1;
        e.hcnt  = m_hit;
        e.mcnt  = m_miss;
        e.t_acc = cyc;
        e.wr    = w;
        e.lat   = l;
        return e;
    endfunction

    task automatic send(input int a, input int w, input int l, input int s);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        k_lat = l;
        wait_left = w;
        stall_left = s;
        q.push_back(make_exp(a, w, l));
        req_valid = 1'b1;
        req_addr  = BT'(a);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = BT'($urandom);
    endtask

    task automatic issue(input int a, input int w, input int l, input int s);
        int guard;
        send(a, w, l, s);
        guard = 0;
        while (q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("rsp_timeout", 64'(guard >= 300), 0);
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 1);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_mem_read", 64'(mem_read), 0);
        check("rst_cache_en_wrt", {62'd0, cache_en, cache_wrt}, 0);
        check("rst_counters", {60'd0, hit_cnt, miss_cnt}, 0);
        check("rst_data_addr", {rsp_data, mem_addr}, 0);
        q.delete();
        present.delete();
        cmem.delete();
        m_hit = 0;
        m_miss = 0;
        n_read_acc = 0;
        n_read_cyc = 0;
        n_fill = 0;
        seen_valid = 0;
        expect_idle = 0;
        stall_left = 0;
        wait_left = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        mem[5] = 32'hDEAD_BEEF;
        do_reset();

        issue(5, 0, 3, 0);          // miss, fill 0xDEADBEEF at 0x1014
        issue(5, 0, 1, 0);          // hit, latency 3
        issue(9, 4, 2, 0);          // waitrequest held 4 cycles
        issue(9, 0, 1, 6);          // hit with 6-cycle response stall

        // Reset in MEM_REQ while waitrequest holds the read.
        send(12, 10, 2, 0);
        repeat (5) @(negedge clk);
        do_reset();

        // Reset in MEM_WAIT; the late readdatavalid must be ignored.
        send(30, 0, 8, 0);
        guard = 0;
        while (n_read_acc == 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("abort_mem_accept", 64'(n_read_acc), 1);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (12) @(negedge clk);
        check("stale_no_fill", 64'(n_fill), 0);
        check("stale_counters", {60'd0, hit_cnt, miss_cnt}, 0);
        check("stale_idle", {62'd0, req_ready, rsp_valid}, 2);

        // Five misses: miss counter saturates at 3.
        for (int i = 0; i < 5; i++) issue(40 + i, i % 2, i % 3, 0);
        check("miss_saturated", 64'(miss_cnt), 3);

        do_reset();
        for (int n = 0; n < 60; n++) begin
            int a;
            a = $urandom_range(0, 11);
            if ($urandom_range(0, 3) == 0 && present.exists(a)) begin
                present.delete(a);
                cmem.delete(a);
            end
            issue(a, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
